// File: rtl/tdm_if.sv
// TDM demultiplexer bus: serial slot inputs from the framer side, channel word
// and status pulses back. The master drives slots, the slave is the demultiplexer.
interface tdm_if #(
    parameter int NCH = 8
);
    logic           en;
    logic           din;
    logic           fsync;
    logic [NCH-1:0] ch;
    logic           frame_valid;
    logic           locked;
    logic           sync_err;
    logic           parity_err;

    modport master (
        output en,
        output din,
        output fsync,
        input  ch,
        input  frame_valid,
        input  locked,
        input  sync_err,
        input  parity_err
    );

    modport slave (
        input  en,
        input  din,
        input  fsync,
        output ch,
        output frame_valid,
        output locked,
        output sync_err,
        output parity_err
    );
endinterface

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer with fsync hunting/locking and resync handling.
// Define TDM_PARITY_EN to append an even-parity slot after the NCH data slots.
//
// state  | meaning
// HUNT   | waiting for fsync; samples without fsync are discarded
// RECV   | collecting first frame after (re)sync, not yet locked
// LOCKED | at least one frame completed, fsync expected on every slot 0
module tdm_demux #(
    parameter int NCH = 8
) (
    input  logic clk,
    input  logic rst_n,
    tdm_if.slave bus
);

`ifdef TDM_PARITY_EN
    localparam int FLEN = NCH + 1;
`else
    localparam int FLEN = NCH;
`endif
    localparam int            CW        = $clog2(FLEN);
    localparam logic [CW-1:0] LAST_SLOT = CW'(FLEN - 1);
    localparam logic [CW-1:0] SLOT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  slot;
    logic [CW-1:0]  slot_nxt;
    logic [NCH-1:0] shadow;
    logic [NCH-1:0] shadow_nxt;
    logic [NCH-1:0] ch_q;
    logic [NCH-1:0] ch_nxt;
    logic           fv_q;
    logic           fv_nxt;
    logic           se_q;
    logic           se_nxt;
`ifdef TDM_PARITY_EN
    logic           pe_q;
    logic           pe_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            slot   <= '0;
            shadow <= '0;
            ch_q   <= '0;
            fv_q   <= 1'b0;
            se_q   <= 1'b0;
`ifdef TDM_PARITY_EN
            pe_q   <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            slot   <= slot_nxt;
            shadow <= shadow_nxt;
            ch_q   <= ch_nxt;
            fv_q   <= fv_nxt;
            se_q   <= se_nxt;
`ifdef TDM_PARITY_EN
            pe_q   <= pe_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        slot_nxt   = slot;
        shadow_nxt = shadow;
        ch_nxt     = ch_q;
        fv_nxt     = 1'b0;
        se_nxt     = 1'b0;
`ifdef TDM_PARITY_EN
        pe_nxt     = 1'b0;
`endif
        if (bus.en) begin
            case (state)
                HUNT: begin
                    if (bus.fsync) begin
                        shadow_nxt    = '0;
                        shadow_nxt[0] = bus.din;
                        slot_nxt      = SLOT_ONE;
                        state_nxt     = RECV;
                    end
                end
                default: begin
                    if ((slot == '0) && !bus.fsync) begin
                        // Lost frame alignment: drop the bit and go hunting.
                        se_nxt    = 1'b1;
                        slot_nxt  = '0;
                        state_nxt = HUNT;
                    end else if ((slot != '0) && bus.fsync) begin
                        // Early fsync restarts the frame with this sample as slot 0.
                        se_nxt        = 1'b1;
                        shadow_nxt    = '0;
                        shadow_nxt[0] = bus.din;
                        slot_nxt      = SLOT_ONE;
                        state_nxt     = RECV;
                    end else begin
                        for (int i = 0; i < NCH; i++) begin
                            if (int'(slot) == i) begin
                                shadow_nxt[i] = bus.din;
                            end
                        end
                        if (slot == LAST_SLOT) begin
                            slot_nxt  = '0;
                            state_nxt = LOCKED;
`ifdef TDM_PARITY_EN
                            // Even parity: data bits plus parity bit must XOR to 0.
                            if ((^{shadow, bus.din}) == 1'b0) begin
                                ch_nxt = shadow;
                                fv_nxt = 1'b1;
                            end else begin
                                pe_nxt = 1'b1;
                            end
`else
                            ch_nxt = shadow_nxt;
                            fv_nxt = 1'b1;
`endif
                        end else begin
                            slot_nxt = slot + SLOT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ch          = ch_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.locked      = (state == LOCKED);
`ifdef TDM_PARITY_EN
    assign bus.parity_err  = pe_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=8): framing, back-to-back frames, resync,
// sync loss, mid-frame reset and, when TDM_PARITY_EN is defined, parity handling.
module tb_tdm_demux;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   fv_count;
    int   se_count;
    logic [7:0] exp_ch;
    int   base_fv;
    int   base_se;

    tdm_if #(.NCH(8)) bus ();

    tdm_demux #(.NCH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.frame_valid) fv_count++;
        if (rst_n && bus.sync_err)    se_count++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input logic d, input logic fs);
        @(negedge clk);
        bus.en    = 1'b1;
        bus.din   = d;
        bus.fsync = fs;
        @(posedge clk);
        #1;
        bus.en    = 1'b0;
        bus.fsync = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.en    = 1'b0;
        bus.fsync = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame starting with fsync; checks intermediate and final outputs.
    task automatic send_frame(input logic [7:0] w, input bit gap, input bit bad_par, input bit resync);
        int flen;
        logic b;
`ifdef TDM_PARITY_EN
        flen = 9;
`else
        flen = 8;
`endif
        for (int i = 0; i < flen; i++) begin
            if (i < 8) b = w[i];
            else       b = (^w) ^ bad_par;
            slot(b, (i == 0) ? 1'b1 : 1'b0);
            if (i == 0) begin
                check("slot0_sync_err", 8'(bus.sync_err), resync ? 8'h01 : 8'h00);
                if (resync) check("resync_unlocked", 8'(bus.locked), 8'h00);
            end
            if (i < flen - 1) begin
                check("partial_fv", 8'(bus.frame_valid), 8'h00);
                check("partial_ch_hold", bus.ch, exp_ch);
                if (gap) idle();
            end
        end
        if (bad_par) begin
            check("par_err_pulse", 8'(bus.parity_err), 8'h01);
            check("par_fv_absent", 8'(bus.frame_valid), 8'h00);
        end else begin
            exp_ch = w;
            check("frame_fv", 8'(bus.frame_valid), 8'h01);
            check("frame_par_err", 8'(bus.parity_err), 8'h00);
        end
        check("frame_ch", bus.ch, exp_ch);
        check("frame_locked", 8'(bus.locked), 8'h01);
        check("frame_sync_err", 8'(bus.sync_err), 8'h00);
        idle();
        check("fv_one_cycle", 8'(bus.frame_valid), 8'h00);
        check("pe_one_cycle", 8'(bus.parity_err), 8'h00);
        check("ch_held", bus.ch, exp_ch);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        fv_count  = 0;
        se_count  = 0;
        exp_ch    = 8'h00;
        bus.en    = 1'b0;
        bus.din   = 1'b0;
        bus.fsync = 1'b0;
        rst_n     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ch", bus.ch, 8'h00);
        check("rst_fv", 8'(bus.frame_valid), 8'h00);
        check("rst_locked", 8'(bus.locked), 8'h00);
        check("rst_se", 8'(bus.sync_err), 8'h00);
        check("rst_pe", 8'(bus.parity_err), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // din 1,0,1,1,0,0,1,0 -> 8'h4D
        send_frame(8'h4D, 1'b0, 1'b0, 1'b0);
        check("first_fv_count", 8'(fv_count), 8'h01);

        base_fv = fv_count;
        base_se = se_count;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("b2b_fv_count", 8'(fv_count - base_fv), 8'h02);
        check("b2b_no_se", 8'(se_count - base_se), 8'h00);

        // fsync arrives at slot 3 while locked
        slot(1'b1, 1'b1);
        slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        base_fv = fv_count;
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        check("resync_fv_count", 8'(fv_count - base_fv), 8'h01);

        // missing fsync at slot 0 while locked
        base_fv = fv_count;
        slot(1'b1, 1'b0);
        check("loss_se", 8'(bus.sync_err), 8'h01);
        check("loss_locked", 8'(bus.locked), 8'h00);
        check("loss_fv", 8'(bus.frame_valid), 8'h00);
        slot(1'b1, 1'b0);
        slot(1'b0, 1'b0);
        check("hunt_se", 8'(bus.sync_err), 8'h00);
        check("hunt_locked", 8'(bus.locked), 8'h00);
        check("hunt_ch", bus.ch, 8'h96);
        check("hunt_no_fv", 8'(fv_count - base_fv), 8'h00);
        send_frame(8'h4D, 1'b0, 1'b0, 1'b0);

        // reset asserted during slot 5
        for (int i = 0; i < 5; i++) slot(1'b1, (i == 0) ? 1'b1 : 1'b0);
        @(negedge clk);
        bus.en  = 1'b1;
        bus.din = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ch", bus.ch, 8'h00);
        check("arst_locked", 8'(bus.locked), 8'h00);
        check("arst_fv", 8'(bus.frame_valid), 8'h00);
        check("arst_se", 8'(bus.sync_err), 8'h00);
        check("arst_pe", 8'(bus.parity_err), 8'h00);
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
        exp_ch = 8'h00;
        base_fv = fv_count;
        for (int i = 0; i < 3; i++) slot(1'b1, 1'b0);
        check("post_rst_no_fv", 8'(fv_count - base_fv), 8'h00);
        check("post_rst_ch", bus.ch, 8'h00);
        check("post_rst_locked", 8'(bus.locked), 8'h00);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);

`ifdef TDM_PARITY_EN
        send_frame(8'h4D, 1'b0, 1'b1, 1'b0);
        check("par_bad_ch_kept", bus.ch, 8'h5A);
        send_frame(8'h4D, 1'b0, 1'b0, 1'b0);
        check("par_good_ch", bus.ch, 8'h4D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL provide parameter NCH, default 8, number of channel slots per frame (legal 2..32).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port en  input  1  slot strobe; din/fsync sampled only when en=1.
REQ-005 SHALL provide port din  input  1  serial TDM data, one bit per slot.
REQ-006 SHALL provide port fsync  input  1  frame sync, marks slot 0.
REQ-007 SHALL provide port ch  output  NCH  registered demultiplexed channel word, bit i = slot i.
REQ-008 SHALL provide port frame_valid  output  1  one-cycle pulse, ch updated.
REQ-009 SHALL provide port locked  output  1  high while in LOCKED state.
REQ-010 SHALL provide port sync_err  output  1  one-cycle pulse on framing violation.
REQ-011 SHALL provide port parity_err  output  1  one-cycle pulse on parity failure (see Configuration).

Function
REQ-012 SHALL implement states HUNT, RECV, LOCKED; en=0 holds all state, counters and shadow data; pulse outputs deassert.
REQ-013 HUNT: sampled fsync=1 SHALL store din in shadow bit 0, set slot counter to 1, enter RECV; fsync=0 SHALL discard din.
REQ-014 RECV/LOCKED: each sampled slot SHALL store din in shadow[slot] and increment slot counter.
REQ-015 On capture of the last slot (NCH-1, or parity slot when enabled) SHALL load ch with the completed frame on that edge, pulse frame_valid on the following cycle, wrap counter to 0, enter LOCKED.
REQ-016 ch SHALL hold its value between frame updates; partial frames SHALL never reach ch.
REQ-017 LOCKED, slot 0, fsync=0: SHALL pulse sync_err, discard bit, enter HUNT, deassert locked.
REQ-018 RECV or LOCKED, slot != 0, fsync=1: SHALL pulse sync_err, discard partial frame, treat sample as slot 0 (store din, counter=1), enter RECV.
REQ-019 fsync=1 at slot 0 in RECV/LOCKED SHALL be accepted as normal framing.
REQ-020 sync_err and frame_valid SHALL never pulse in the same cycle; on a resync cycle only sync_err.
REQ-021 Latency SHALL be one cycle from last-slot sample edge to frame_valid=1; ch valid concurrently with frame_valid.
REQ-022 Slot counter SHALL be ceil(log2(frame length)) bits and never exceed frame length-1.

Reset
REQ-023 rst_n=0 SHALL immediately force state HUNT, slot counter 0, shadow 0, ch 0, frame_valid 0, locked 0, sync_err 0, parity_err 0.
REQ-024 Reset mid-frame SHALL discard the partial frame; first frame after release requires fsync.

Configuration
REQ-025 Macro TDM_PARITY_EN defined: frame length SHALL be NCH+1, final slot an even-parity bit over slots 0..NCH-1.
REQ-026 With TDM_PARITY_EN, parity mismatch SHALL pulse parity_err instead of frame_valid, leave ch unchanged, remain LOCKED.
REQ-027 Without TDM_PARITY_EN: frame length SHALL be NCH, parity_err tied 0, no parity logic synthesized.

Verification
REQ-028 NCH=8, en=1, fsync at slot 0, din bits 1,0,1,1,0,0,1,0 -> ch=8'h4D one cycle after slot 7, frame_valid one pulse, locked=1.
REQ-029 Two back-to-back frames 8'hA5 then 8'h3C, en toggling 1,0 each cycle -> ch 8'hA5 then 8'h3C, exactly two frame_valid pulses, no sync_err.
REQ-030 Locked, fsync asserted at slot 3 -> sync_err pulse, ch unchanged, next 8 slots form new frame with valid update.
REQ-031 Locked, fsync absent at slot 0 -> sync_err pulse, locked=0, HUNT until next fsync, no frame_valid.
REQ-032 rst_n pulsed low at slot 5 -> all outputs 0 asynchronously, no frame_valid until a full new fsync-aligned frame.
REQ-033 TDM_PARITY_EN, data 8'h4D with parity bit 1 -> parity_err pulse, ch retains previous value; parity bit 0 -> frame_valid, ch=8'h4D.
